key_filter: RTL and testbench



---
 rtl/key_filter.sv | 174 +++++++++++++++++
 tb/tb_key_filter.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_filter.sv
// Debounced push-button reader: 2-flop synchroniser, bounce filter FSM, press/release/long pulses.
// Optional auto-repeat of key_flag after a long press is enabled by defining KEY_REPEAT_EN.
module key_filter #(
  parameter logic [31:0] CNT_MAX    = 32'd999_999,
  parameter logic [31:0] LONG_MAX   = 32'd49_999_999,
  parameter logic [31:0] REPEAT_MAX = 32'd9_999_999,
  parameter logic        KEY_ACTIVE = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic key_in,
  output logic key_flag,
  output logic key_release,
  output logic key_long,
  output logic key_state
);

  typedef enum logic [1:0] {
    IDLE           = 2'd0,
    PRESS_FILTER   = 2'd1,
    DOWN           = 2'd2,
    RELEASE_FILTER = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        sync1_q, sync1_d;
  logic        sync2_q, sync2_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] hold_cnt_q, hold_cnt_d;
  logic        long_done_q, long_done_d;
  logic        key_flag_q, key_flag_d;
  logic        key_release_q, key_release_d;
  logic        key_long_q, key_long_d;
  logic        key_state_q, key_state_d;
  logic        key_s;
`ifdef KEY_REPEAT_EN
  logic [31:0] rep_cnt_q, rep_cnt_d;
`endif

  assign key_s       = (sync2_q == KEY_ACTIVE);
  assign key_flag    = key_flag_q;
  assign key_release = key_release_q;
  assign key_long    = key_long_q;
  assign key_state   = key_state_q;

  // Next-state, counter and pulse computation for the debounce FSM.
  always_comb begin
    sync1_d       = key_in;
    sync2_d       = sync1_q;
    state_d       = state_q;
    cnt_d         = cnt_q;
    hold_cnt_d    = hold_cnt_q;
    long_done_d   = long_done_q;
    key_flag_d    = 1'b0;
    key_release_d = 1'b0;
    key_long_d    = 1'b0;
    key_state_d   = key_state_q;
`ifdef KEY_REPEAT_EN
    rep_cnt_d     = rep_cnt_q;
`endif
    case (state_q)
      IDLE: begin
`ifdef KEY_REPEAT_EN
        rep_cnt_d = 32'd0;
`endif
        cnt_d = 32'd0;
        if (key_s) begin
          state_d = PRESS_FILTER;
        end else begin
          state_d = IDLE;
        end
      end
      PRESS_FILTER: begin
        if (!key_s) begin
          state_d = IDLE;
          cnt_d   = 32'd0;
        end else if (cnt_q == CNT_MAX) begin
          state_d     = DOWN;
          key_flag_d  = 1'b1;
          key_state_d = 1'b1;
          hold_cnt_d  = 32'd0;
          long_done_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      DOWN: begin
        if (!key_s) begin
          state_d = RELEASE_FILTER;
          cnt_d   = 32'd0;
        end else begin
          state_d = DOWN;
        end
        // Hold timing runs on every DOWN cycle, so a release edge cannot swallow key_long.
        if (!long_done_q) begin
          if (hold_cnt_q == LONG_MAX) begin
            key_long_d  = 1'b1;
            long_done_d = 1'b1;
`ifdef KEY_REPEAT_EN
            rep_cnt_d   = 32'd0;
`endif
          end else begin
            hold_cnt_d = hold_cnt_q + 32'd1;
          end
        end else begin
`ifdef KEY_REPEAT_EN
          if (rep_cnt_q == REPEAT_MAX) begin
            key_flag_d = 1'b1;
            rep_cnt_d  = 32'd0;
          end else begin
            rep_cnt_d = rep_cnt_q + 32'd1;
          end
`else
          hold_cnt_d = hold_cnt_q;
`endif
        end
      end
      RELEASE_FILTER: begin
        if (key_s) begin
          state_d = DOWN;
        end else if (cnt_q == CNT_MAX) begin
          state_d       = IDLE;
          key_release_d = 1'b1;
          key_state_d   = 1'b0;
          hold_cnt_d    = 32'd0;
          long_done_d   = 1'b0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      default: begin
        state_d     = IDLE;
        cnt_d       = 32'd0;
        hold_cnt_d  = 32'd0;
        long_done_d = 1'b0;
        key_state_d = 1'b0;
      end
    endcase
  end

  // State register; synchroniser resets to the released level to avoid a spurious press.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q       <= ~KEY_ACTIVE;
      sync2_q       <= ~KEY_ACTIVE;
      state_q       <= IDLE;
      cnt_q         <= 32'd0;
      hold_cnt_q    <= 32'd0;
      long_done_q   <= 1'b0;
      key_flag_q    <= 1'b0;
      key_release_q <= 1'b0;
      key_long_q    <= 1'b0;
      key_state_q   <= 1'b0;
`ifdef KEY_REPEAT_EN
      rep_cnt_q     <= 32'd0;
`endif
    end else begin
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      hold_cnt_q    <= hold_cnt_d;
      long_done_q   <= long_done_d;
      key_flag_q    <= key_flag_d;
      key_release_q <= key_release_d;
      key_long_q    <= key_long_d;
      key_state_q   <= key_state_d;
`ifdef KEY_REPEAT_EN
      rep_cnt_q     <= rep_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_key_filter.sv
// Self-checking bench for key_filter: directed scenarios plus random key activity,
// all checked against a run-length based reference model of the debounce rules.
module tb_key_filter;

  localparam int   CNT  = 9;
  localparam int   LONG = 49;
  localparam int   REP  = 19;
  localparam logic KA   = 1'b0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic key_in = 1'b1;
  logic key_flag, key_release, key_long, key_state;

  int n_checks = 0;
  int n_fail   = 0;
  int edge_n   = 0;

  // reference model state
  logic m_pipe[$];
  logic m_level = 1'b0;
  int   m_run   = 0;
  int   m_down  = 0;
  logic m_flag = 1'b0, m_rel = 1'b0, m_long = 1'b0;

  int flag_edges[$];
  int rel_edges[$];
  int long_edges[$];

  key_filter #(
    .CNT_MAX(32'd9), .LONG_MAX(32'd49), .REPEAT_MAX(32'd19), .KEY_ACTIVE(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .key_in(key_in),
    .key_flag(key_flag), .key_release(key_release), .key_long(key_long), .key_state(key_state)
  );

  always #5 clk = ~clk;

  // Model: the debounced level flips once the synchronised key has disagreed with it
  // for CNT+2 consecutive samples; hold time counts samples spent settled in the pressed level.
  task automatic model_step(input logic k, input logic r);
    logic ks;
    m_flag = 1'b0; m_rel = 1'b0; m_long = 1'b0;
    if (r) begin
      m_level = 1'b0; m_run = 0; m_down = 0;
      m_pipe.delete(); m_pipe.push_back(~KA); m_pipe.push_back(~KA);
    end else begin
      ks = (m_pipe[0] == KA);
      void'(m_pipe.pop_front());
      m_pipe.push_back(k);
      if (m_level && m_run == 0) begin
        m_down++;
        if (m_down == LONG + 1) m_long = 1'b1;
`ifdef KEY_REPEAT_EN
        else if (m_down > LONG + 1 && ((m_down - LONG - 1) % (REP + 1)) == 0) m_flag = 1'b1;
`endif
      end
      if (ks != m_level) begin
        m_run++;
        if (m_run == CNT + 2) begin
          m_level = ~m_level; m_run = 0; m_down = 0;
          if (m_level) m_flag = 1'b1;
          else m_rel = 1'b1;
        end
      end else begin
        m_run = 0;
      end
    end
  endtask

  task automatic cycle(input logic k, input logic r);
    @(negedge clk);
    key_in = k;
    rst    = r;
    @(posedge clk);
    edge_n++;
    model_step(k, r);
    #1;
    if (key_flag === 1'b1)    flag_edges.push_back(edge_n);
    if (key_release === 1'b1) rel_edges.push_back(edge_n);
    if (key_long === 1'b1)    long_edges.push_back(edge_n);
  endtask

  task automatic clear_logs();
    flag_edges.delete(); rel_edges.delete(); long_edges.delete();
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1);
    for (int i = 0; i < 30; i++) begin
      cycle(1'b1, 1'b0);
      n_checks++;
      if ({key_flag, key_release, key_long, key_state} !== 4'b0000) begin
        n_fail++;
        $display("FAIL reset_outputs edge %0d: got %b expected 0000", edge_n,
                 {key_flag, key_release, key_long, key_state});
      end
    end
  endtask

  task automatic test_clean_press();
    int k;
    clear_logs();
    k = edge_n + 1;
    for (int i = 0; i < 40; i++) begin
      cycle(1'b0, 1'b0);
      n_checks++;
      if ({key_flag, key_release, key_long, key_state} !== {m_flag, m_rel, m_long, m_level}) begin
        n_fail++;
        $display("FAIL press_model edge %0d: got %b expected %b", edge_n,
                 {key_flag, key_release, key_long, key_state}, {m_flag, m_rel, m_long, m_level});
      end
      if (edge_n == k + 11 || edge_n == k + 12) begin
        n_checks++;
        if (key_state !== (edge_n == k + 12)) begin
          n_fail++;
          $display("FAIL press_state edge %0d: got %b", edge_n, key_state);
        end
      end
    end
    n_checks++;
    if (flag_edges.size() != 1 || flag_edges[0] != k + 12) begin
      n_fail++;
      $display("FAIL press_flag: got %0d pulses (first at %0d) expected 1 at %0d",
               flag_edges.size(), (flag_edges.size() > 0) ? flag_edges[0] : -1, k + 12);
    end
    n_checks++;
    if (long_edges.size() != 0) begin
      n_fail++;
      $display("FAIL press_nolong: got %0d key_long pulses expected 0", long_edges.size());
    end
    for (int i = 0; i < 20; i++) cycle(1'b1, 1'b0);
  endtask

  task automatic test_bounce();
    int k;
    clear_logs();
    for (int i = 0; i < 32; i++) begin
      cycle(((i / 4) % 2 == 0) ? 1'b0 : 1'b1, 1'b0);
      n_checks++;
      if (key_flag !== 1'b0 || key_state !== m_level) begin
        n_fail++;
        $display("FAIL bounce_quiet edge %0d: got flag %b state %b expected 0 %b",
                 edge_n, key_flag, key_state, m_level);
      end
    end
    k = edge_n + 1;
    for (int i = 0; i < 20; i++) cycle(1'b0, 1'b0);
    n_checks++;
    if (flag_edges.size() != 1 || flag_edges[0] != k + 12) begin
      n_fail++;
      $display("FAIL bounce_flag: got %0d pulses (first at %0d) expected 1 at %0d",
               flag_edges.size(), (flag_edges.size() > 0) ? flag_edges[0] : -1, k + 12);
    end
    for (int i = 0; i < 20; i++) cycle(1'b1, 1'b0);
  endtask

  task automatic test_release();
    int k, m;
    for (int i = 0; i < 20; i++) cycle(1'b0, 1'b0);
    clear_logs();
    k = edge_n + 1;
    m = k + 8;
    for (int i = 0; i < 28; i++) begin
      cycle((i >= 5 && i < 8) ? 1'b0 : 1'b1, 1'b0);
      n_checks++;
      if ({key_flag, key_release, key_long, key_state} !== {m_flag, m_rel, m_long, m_level}) begin
        n_fail++;
        $display("FAIL release_model edge %0d: got %b expected %b", edge_n,
                 {key_flag, key_release, key_long, key_state}, {m_flag, m_rel, m_long, m_level});
      end
      if (edge_n == m + 11 || edge_n == m + 12) begin
        n_checks++;
        if (key_state !== (edge_n == m + 11)) begin
          n_fail++;
          $display("FAIL release_state edge %0d: got %b", edge_n, key_state);
        end
      end
    end
    n_checks++;
    if (rel_edges.size() != 1 || rel_edges[0] != m + 12) begin
      n_fail++;
      $display("FAIL release_pulse: got %0d pulses (first at %0d) expected 1 at %0d",
               rel_edges.size(), (rel_edges.size() > 0) ? rel_edges[0] : -1, m + 12);
    end
  endtask

  task automatic test_long_press();
    int k;
    int exp_flags[$];
    clear_logs();
    k = edge_n + 1;
    exp_flags.push_back(k + 12);
`ifdef KEY_REPEAT_EN
    exp_flags.push_back(k + 82);
    exp_flags.push_back(k + 102);
    exp_flags.push_back(k + 122);
    exp_flags.push_back(k + 142);
`endif
    for (int i = 0; i < 150; i++) begin
      cycle(1'b0, 1'b0);
      n_checks++;
      if (key_long === 1'b1 && key_flag === 1'b1) begin
        n_fail++;
        $display("FAIL long_coincide edge %0d: key_long and key_flag both high", edge_n);
      end
    end
    n_checks++;
    if (long_edges.size() != 1 || long_edges[0] != k + 62) begin
      n_fail++;
      $display("FAIL long_pulse: got %0d pulses (first at %0d) expected 1 at %0d",
               long_edges.size(), (long_edges.size() > 0) ? long_edges[0] : -1, k + 62);
    end
    n_checks++;
    if (flag_edges.size() != exp_flags.size()) begin
      n_fail++;
      $display("FAIL long_flag_count: got %0d expected %0d", flag_edges.size(), exp_flags.size());
    end else begin
      foreach (exp_flags[i]) begin
        n_checks++;
        if (flag_edges[i] != exp_flags[i]) begin
          n_fail++;
          $display("FAIL long_flag_edge[%0d]: got %0d expected %0d", i, flag_edges[i], exp_flags[i]);
        end
      end
    end
    for (int i = 0; i < 20; i++) cycle(1'b1, 1'b0);
  endtask

  task automatic test_reset_mid_press();
    int r;
    for (int i = 0; i < 20; i++) cycle(1'b0, 1'b0);
    clear_logs();
    cycle(1'b0, 1'b1);
    r = edge_n;
    n_checks++;
    if ({key_flag, key_release, key_long, key_state} !== 4'b0000) begin
      n_fail++;
      $display("FAIL midreset_clear: got %b expected 0000", {key_flag, key_release, key_long, key_state});
    end
    for (int i = 0; i < 20; i++) cycle(1'b0, 1'b0);
    n_checks++;
    if (flag_edges.size() != 1 || flag_edges[0] != r + 13) begin
      n_fail++;
      $display("FAIL midreset_flag: got %0d pulses (first at %0d) expected 1 at %0d",
               flag_edges.size(), (flag_edges.size() > 0) ? flag_edges[0] : -1, r + 13);
    end
    n_checks++;
    if (rel_edges.size() != 0) begin
      n_fail++;
      $display("FAIL midreset_norelease: got %0d key_release pulses expected 0", rel_edges.size());
    end
    for (int i = 0; i < 20; i++) cycle(1'b1, 1'b0);
  endtask

  task automatic test_random();
    logic v;
    int   len;
    int   done;
    v = 1'b1;
    done = 0;
    while (done < 3000) begin
      v = ~v;
      len = ($urandom_range(0, 3) == 0) ? $urandom_range(30, 140) : $urandom_range(1, 14);
      for (int i = 0; i < len; i++) begin
        cycle(v, ($urandom_range(0, 999) == 0) ? 1'b1 : 1'b0);
        n_checks++;
        if ({key_flag, key_release, key_long, key_state} !== {m_flag, m_rel, m_long, m_level}) begin
          n_fail++;
          $display("FAIL random_model edge %0d: got %b expected %b", edge_n,
                   {key_flag, key_release, key_long, key_state}, {m_flag, m_rel, m_long, m_level});
        end
      end
      done += len;
    end
  endtask

  initial begin
    m_pipe.push_back(~KA);
    m_pipe.push_back(~KA);
    test_reset();
    test_clean_press();
    test_bounce();
    test_release();
    test_long_press();
    test_reset_mid_press();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
